// File: rtl/usb_stream_pkg.sv
// Shared constants for the USB CDC stream loopback: mode encodings and ASCII helpers.
// Optional statistics counters in the top are enabled with USB_LOOPBACK_STATS_EN.
package usb_stream_pkg;

    localparam logic [1:0] MODE_RAW   = 2'd0;
    localparam logic [1:0] MODE_UPPER = 2'd1;
    localparam logic [1:0] MODE_LINE  = 2'd2;
    localparam logic [1:0] MODE_SINK  = 2'd3;

    localparam logic [7:0] ASCII_LOWER_A     = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_DELTA  = 8'h20;
    localparam logic [7:0] TERM_CHAR_DEFAULT = 8'h0D;

    // Lower-case ASCII letters map to upper case; every other byte passes through.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if ((b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z)) begin
            r = b - ASCII_CASE_DELTA;
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_stream_fifo.sv
// Synchronous FIFO with a registered head word, registered level and full/empty flags.
// Next-cycle full/empty are exported (_c) so the parent can register its handshake outputs.
module usb_stream_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic                    pop_i,
    output logic [DATA_W-1:0]       head_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    full_nxt_c,
    output logic                    empty_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [PW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              full_q, empty_q;
    logic              push_eff, pop_eff;

    // Pointer update; the head forwards the write data when the written slot becomes the head.
    always_comb begin
        push_eff = push_i && !full_q;
        pop_eff  = pop_i && !empty_q;
        wptr_d   = wptr_q + PW'(push_eff);
        rptr_d   = rptr_q + PW'(pop_eff);
        level_d  = wptr_d - rptr_d;
        head_d   = mem_q[rptr_d[AW-1:0]];
        if (push_eff && (wptr_q == rptr_d)) begin
            head_d = wdata_i;
        end
        full_nxt_c  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
        empty_nxt_c = (wptr_d == rptr_d);
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            head_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            head_q  <= head_d;
            full_q  <= full_nxt_c;
            empty_q <= empty_nxt_c;
        end
    end

    assign head_o  = head_q;
    assign level_o = level_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/usb_stream_loopback.sv
// Loopback engine between usb_uart out and in streams: elastic FIFO, RAW/UPPER/LINE/SINK modes.
// Define USB_LOOPBACK_STATS_EN to add saturating rx_count/tx_count transfer counters.
module usb_stream_loopback
    import usb_stream_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 64,
    parameter logic [7:0]  TERM_CHAR = TERM_CHAR_DEFAULT,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                    clk_48mhz,
    input  logic                    reset_n,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic [1:0]              mode,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    forced_release
`ifdef USB_LOOPBACK_STATS_EN
    ,
    output logic [CNT_W-1:0]        rx_count,
    output logic [CNT_W-1:0]        tx_count
`endif
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [1:0]        mode_q, mode_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              release_q, release_d;
    logic              forced_q, forced_d;
    logic [LW-1:0]     line_cnt_q, line_cnt_d;

    logic              accept, push, pop;
    logic              term_push, term_pop, force_set;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] fifo_head;
    logic [LW-1:0]     fifo_level;
    logic              fifo_full, fifo_empty;
    logic              full_nxt_c, empty_nxt_c;

    // Write-side datapath: SINK accepts but never pushes; UPPER converts at write time.
    always_comb begin
        accept = in_valid && in_ready_q;
        push   = accept && (mode_q != MODE_SINK);
        pop    = out_valid_q && out_ready;
        wdata  = in_data;
        if (mode_q == MODE_UPPER) begin
            wdata[7:0] = to_upper(in_data[7:0]);
        end
        term_push = push && (wdata[7:0] == TERM_CHAR);
        term_pop  = pop && (fifo_head[7:0] == TERM_CHAR);
    end

    usb_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk_48mhz),
        .rst_n       (reset_n),
        .push_i      (push),
        .wdata_i     (wdata),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .level_o     (fifo_level),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .full_nxt_c  (full_nxt_c),
        .empty_nxt_c (empty_nxt_c)
    );

    // Control next state: terminator count, forced release, mode latch and handshake flags.
    always_comb begin
        line_cnt_d = line_cnt_q;
        case ({term_push, term_pop})
            2'b10:   line_cnt_d = line_cnt_q + LW'(1);
            2'b01:   line_cnt_d = line_cnt_q - LW'(1);
            default: line_cnt_d = line_cnt_q;
        endcase

        force_set = (mode_q == MODE_LINE) && fifo_full && (line_cnt_q == '0) && !release_q;
        forced_d  = force_set;

        release_d = release_q;
        if (empty_nxt_c) begin
            release_d = 1'b0;
        end else if (force_set) begin
            release_d = 1'b1;
        end

        // Mode only changes with nothing buffered, so queued bytes keep their processing.
        mode_d = mode_q;
        if (fifo_empty && !push) begin
            mode_d = mode;
        end

        out_valid_d = !empty_nxt_c &&
                      ((mode_d != MODE_LINE) || (line_cnt_d != '0) || release_d);
        in_ready_d  = (mode_d == MODE_SINK) || !full_nxt_c;
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= MODE_RAW;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            release_q   <= 1'b0;
            forced_q    <= 1'b0;
            line_cnt_q  <= '0;
        end else begin
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            release_q   <= release_d;
            forced_q    <= forced_d;
            line_cnt_q  <= line_cnt_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_data       = fifo_head;
    assign level          = fifo_level;
    assign forced_release = forced_q;

`ifdef USB_LOOPBACK_STATS_EN
    logic [CNT_W-1:0] rx_q, rx_d;
    logic [CNT_W-1:0] tx_q, tx_d;

    // Saturating transfer counters; SINK-discarded bytes still count as received.
    always_comb begin
        rx_d = rx_q;
        tx_d = tx_q;
        if (accept && (rx_q != '1)) begin
            rx_d = rx_q + CNT_W'(1);
        end
        if (pop && (tx_q != '1)) begin
            tx_d = tx_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            rx_q <= '0;
            tx_q <= '0;
        end else begin
            rx_q <= rx_d;
            tx_q <= tx_d;
        end
    end

    assign rx_count = rx_q;
    assign tx_count = tx_q;
`endif

endmodule

// File: tb/tb_usb_stream_loopback.sv
// Directed bench for usb_stream_loopback: RAW, UPPER, LINE, overflow release, backpressure,
// reset and SINK switching. Counter ports are checked when USB_LOOPBACK_STATS_EN is defined.
module tb_usb_stream_loopback;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned LW    = 7;

    logic          clk_48mhz = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    mode;
    logic [LW-1:0] level;
    logic          forced_release;
`ifdef USB_LOOPBACK_STATS_EN
    logic [15:0]   rx_count;
    logic [15:0]   tx_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int fr_cnt   = 0;
    logic [7:0] exp_q[$];

    usb_stream_loopback #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .TERM_CHAR (8'h0D),
        .CNT_W     (16)
    ) dut (
        .clk_48mhz      (clk_48mhz),
        .reset_n        (reset_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .mode           (mode),
        .level          (level),
        .forced_release (forced_release)
`ifdef USB_LOOPBACK_STATS_EN
        ,
        .rx_count       (rx_count),
        .tx_count       (tx_count)
`endif
    );

    always #5 clk_48mhz = ~clk_48mhz;

    always @(negedge clk_48mhz) begin
        if (forced_release) fr_cnt++;
    end

    task automatic tick();
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [7:0] b);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            n_assert++;
            n_fail++;
            $error("FAIL push_timeout: observed in_ready=0 expected in_ready=1 within 200 cycles");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        int guard;
        logic [7:0] e;
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            guard = 0;
            while (!out_valid && guard < 200) begin
                tick();
                guard++;
            end
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_data"}, 32'(out_data), 32'(e));
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        tick();
        tick();
    endtask

    initial begin
        int seen;
        int fr_base;
        int nv;
        int acc;
        int bad;
        int lvl_bad;
        logic [7:0] e;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        mode      = 2'd0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_forced_release", 32'(forced_release), 32'd0);
        @(negedge clk_48mhz);
        reset_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // RAW: 41,62,0D streamed with the sink always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h41;
        chk("raw_pre_valid", 32'(out_valid), 32'd0);
        tick();
        chk("raw_lat_valid", 32'(out_valid), 32'd1);
        chk("raw_d0", 32'(out_data), 32'h41);
        in_data = 8'h62;
        tick();
        chk("raw_d1_valid", 32'(out_valid), 32'd1);
        chk("raw_d1", 32'(out_data), 32'h62);
        in_data = 8'h0D;
        tick();
        chk("raw_d2_valid", 32'(out_valid), 32'd1);
        chk("raw_d2", 32'(out_data), 32'h0D);
        in_valid = 1'b0;
        tick();
        chk("raw_end_valid", 32'(out_valid), 32'd0);
        chk("raw_end_level", 32'(level), 32'd0);
        out_ready = 1'b0;

        // UPPER: "abz{" -> "ABZ{"
        set_mode(2'd1);
        push_one(8'h61);
        push_one(8'h62);
        push_one(8'h7A);
        push_one(8'h7B);
        chk("upper_level", 32'(level), 32'd4);
        exp_q = '{8'h41, 8'h42, 8'h5A, 8'h7B};
        drain_check("upper");
        chk("upper_end_level", 32'(level), 32'd0);

        // LINE: held until the terminator arrives, then released back-to-back
        set_mode(2'd2);
        out_ready = 1'b1;
        push_one(8'h68);
        push_one(8'h69);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("line_hold", 32'(seen), 32'd0);
        chk("line_hold_level", 32'(level), 32'd2);
        push_one(8'h0D);
        chk("line_v0", 32'(out_valid), 32'd1);
        chk("line_d0", 32'(out_data), 32'h68);
        tick();
        chk("line_v1", 32'(out_valid), 32'd1);
        chk("line_d1", 32'(out_data), 32'h69);
        tick();
        chk("line_v2", 32'(out_valid), 32'd1);
        chk("line_d2", 32'(out_data), 32'h0D);
        tick();
        chk("line_end_valid", 32'(out_valid), 32'd0);
        chk("line_end_level", 32'(level), 32'd0);
        out_ready = 1'b0;

        // LINE overflow: 64 bytes without terminator force a release
        fr_base = fr_cnt;
        for (int i = 0; i < 64; i++) begin
            push_one(8'(8'h40 + i));
            exp_q.push_back(8'(8'h40 + i));
        end
        chk("ovf_level_full", 32'(level), 32'd64);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (5) tick();
        in_valid = 1'b0;
        chk("ovf_level_hold", 32'(level), 32'd64);
        chk("ovf_forced_pulses", 32'(fr_cnt - fr_base), 32'd1);
        chk("ovf_release_valid", 32'(out_valid), 32'd1);
        drain_check("ovf");
        chk("ovf_end_level", 32'(level), 32'd0);
        chk("ovf_forced_pulses_end", 32'(fr_cnt - fr_base), 32'd1);

        // RAW backpressure: 70 attempts with sink stalled, then steady push+pop at full
        set_mode(2'd0);
        nv  = 0;
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 70; i++) begin
            in_data = 8'(nv);
            if (in_ready) begin
                exp_q.push_back(8'(nv));
                nv++;
                acc++;
            end
            tick();
        end
        chk("bp_accepted", 32'(acc), 32'd64);
        chk("bp_level_full", 32'(level), 32'd64);
        out_ready = 1'b1;
        bad     = 0;
        lvl_bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'(nv);
            if (in_ready) begin
                exp_q.push_back(8'(nv));
                nv++;
            end
            if (out_valid) begin
                e = exp_q.pop_front();
                if (out_data !== e) bad++;
            end
            tick();
            if (level !== 7'd63) lvl_bad++;
        end
        in_valid = 1'b0;
        chk("bp_stream_order", 32'(bad), 32'd0);
        chk("bp_level_steady", 32'(lvl_bad), 32'd0);
        drain_check("bp_tail");
        chk("bp_end_level", 32'(level), 32'd0);

        // Reset mid-operation discards the queue immediately
        for (int i = 0; i < 10; i++) push_one(8'(8'hA0 + i));
        chk("mid_level", 32'(level), 32'd10);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk_48mhz);
        reset_n = 1'b1;
        tick();

        // SINK requested while non-empty: queued bytes drain unchanged, later input is dropped
        for (int i = 0; i < 10; i++) begin
            push_one(8'(8'hB0 + i));
            exp_q.push_back(8'(8'hB0 + i));
        end
        mode = 2'd3;
        tick();
        tick();
        chk("sink_hold_level", 32'(level), 32'd10);
        drain_check("sink_drain");
        tick();
        push_one(8'h11);
        push_one(8'h0D);
        push_one(8'h7A);
        chk("sink_level", 32'(level), 32'd0);
        chk("sink_out_valid", 32'(out_valid), 32'd0);
        chk("sink_in_ready", 32'(in_ready), 32'd1);
`ifdef USB_LOOPBACK_STATS_EN
        chk("stats_rx", 32'(rx_count), 32'd13);
        chk("stats_tx", 32'(tx_count), 32'd10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
